branch_jump_target_arbiter: RTL and testbench

Shares one `shift_left_2` instance and one 32-bit adder between two requesters: the branch-target path and the jump-target path. Each requester hands over operands through a valid/ready handshake. The block arbitrates between them, computes the target word address, and returns it on a registered valid/ready output port. It sits between the decode stage and the next-PC mux in the multicycle/pipelined successor of the monocycle core.

---
 rtl/branch_jump_target_arbiter_pkg.sv | 21 ++
 rtl/shift_left_2.sv | 9 +
 rtl/branch_jump_target_arbiter.sv | 113 +++++++++++
 tb/tb_branch_jump_target_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_jump_target_arbiter_pkg.sv
// target_arb_pkg: FSM state encodings, requester source codes and the
// latched-request record shared by the branch/jump target arbiter.
package target_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic SRC_BRANCH = 1'b0;
    localparam logic SRC_JUMP   = 1'b1;

    // Operands captured at acceptance; opnd is what feeds the shared shifter.
    typedef struct packed {
        logic        src;
        logic [31:0] pc;
        logic [31:0] opnd;
    } req_t;

endpackage

// File: rtl/shift_left_2.sv
// shift_left_2: word-offset to byte-offset shifter (top two bits dropped).
module shift_left_2 (
    input  logic [31:0] operand,
    output logic [31:0] shifted
);

    assign shifted = operand << 2;

endmodule

// File: rtl/branch_jump_target_arbiter.sv
// branch_jump_target_arbiter: shares one shift_left_2 and one 32-bit adder
// between the branch-target and jump-target requesters. IDLE accepts one
// request, CALC computes and registers the target, HOLD presents it until
// the consumer takes it.
// Build option: define TARGET_ARB_RR_EN for round-robin arbitration;
// otherwise branch has fixed priority over jump.
module branch_jump_target_arbiter
    import target_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [31:0] br_pc_plus4,
    input  logic [31:0] br_imm_ext,
    input  logic        j_valid,
    output logic        j_ready,
    input  logic [31:0] j_pc_plus4,
    input  logic [25:0] j_index,
    output logic        tgt_valid,
    input  logic        tgt_ready,
    output logic [31:0] tgt_addr,
    output logic        tgt_src
);

    state_t      state_q, state_d;
    req_t        req_q;
    logic        pick_jump;
    logic        idle;
    logic        accept;
    logic [31:0] shifted;
    logic [31:0] br_sum;
    logic [31:0] result;
    logic [31:0] tgt_addr_q;
    logic        tgt_src_q;

`ifdef TARGET_ARB_RR_EN
    logic last_q;

    // On a tie, whoever was not granted last time wins.
    always_comb pick_jump = j_valid && (!br_valid || (last_q == SRC_BRANCH));

    // Remember the last grant; reset as "jump" so branch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= SRC_JUMP;
        else if (accept)
            last_q <= pick_jump ? SRC_JUMP : SRC_BRANCH;
    end
`else
    // Fixed priority: jump only goes when branch is not asking.
    always_comb pick_jump = j_valid && !br_valid;
`endif

    // Readies are gated by reset so nothing is accepted while rst_n is low.
    assign idle     = rst_n && (state_q == ST_IDLE);
    assign accept   = idle && (br_valid || j_valid);
    assign br_ready = accept && !pick_jump;
    assign j_ready  = accept && pick_jump;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: one request per trip IDLE -> CALC -> HOLD -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_CALC;
            ST_CALC:                state_d = ST_HOLD;
            ST_HOLD: if (tgt_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Capture the winner's operands; jump index is zero-extended for the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            req_q <= '0;
        else if (accept)
            req_q <= pick_jump ? '{src: SRC_JUMP,   pc: j_pc_plus4,  opnd: {6'b0, j_index}}
                               : '{src: SRC_BRANCH, pc: br_pc_plus4, opnd: br_imm_ext};
    end

    shift_left_2 u_shl2 (
        .operand (req_q.opnd),
        .shifted (shifted)
    );

    // Branch sum wraps modulo 2^32; jump keeps the PC's 256 MB region.
    assign br_sum = req_q.pc + shifted;
    assign result = (req_q.src == SRC_JUMP) ? {req_q.pc[31:28], shifted[27:0]} : br_sum;

    // Register the target in CALC; it stays put through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_addr_q <= '0;
            tgt_src_q  <= SRC_BRANCH;
        end else if (state_q == ST_CALC) begin
            tgt_addr_q <= result;
            tgt_src_q  <= req_q.src;
        end
    end

    assign tgt_valid = (state_q == ST_HOLD);
    assign tgt_addr  = tgt_addr_q;
    assign tgt_src   = tgt_src_q;

endmodule

// File: tb/tb_branch_jump_target_arbiter.sv
// tb_branch_jump_target_arbiter: directed test-plan vectors with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (one outstanding request, result due two cycles
// after acceptance, held until taken).
module tb_branch_jump_target_arbiter;
    import target_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0, j_valid = 1'b0, tgt_ready = 1'b1;
    logic [31:0] br_pc_plus4 = '0, br_imm_ext = '0, j_pc_plus4 = '0;
    logic [25:0] j_index = '0;
    logic        br_ready, j_ready, tgt_valid, tgt_src;
    logic [31:0] tgt_addr;

    int checks = 0;
    int errors = 0;

    branch_jump_target_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_pc_plus4 (br_pc_plus4),
        .br_imm_ext  (br_imm_ext),
        .j_valid     (j_valid),
        .j_ready     (j_ready),
        .j_pc_plus4  (j_pc_plus4),
        .j_index     (j_index),
        .tgt_valid   (tgt_valid),
        .tgt_ready   (tgt_ready),
        .tgt_addr    (tgt_addr),
        .tgt_src     (tgt_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_pend = 1'b0;
    int          m_cyc = 0;
    int          m_acc = 0;
    logic [31:0] m_addr = '0;
    logic        m_src = 1'b0;
    logic        m_last = SRC_JUMP;

    always @(negedge clk) begin
        bit eb, ej, ev;
        m_cyc++;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_last = SRC_JUMP;
            chk("rst_valid", 32'(tgt_valid), 32'd0);
            chk("rst_addr",  tgt_addr,       32'd0);
            chk("rst_src",   32'(tgt_src),   32'd0);
            chk("rst_brrdy", 32'(br_ready),  32'd0);
            chk("rst_jrdy",  32'(j_ready),   32'd0);
        end else begin
            ev = m_pend && (m_cyc >= m_acc + 2);
            eb = 1'b0;
            ej = 1'b0;
            if (!m_pend && (br_valid || j_valid)) begin
                if (br_valid && j_valid) begin
`ifdef TARGET_ARB_RR_EN
                    ej = (m_last == SRC_BRANCH);
`else
                    ej = 1'b0;
`endif
                end else begin
                    ej = j_valid;
                end
                eb = !ej;
            end
            chk("m_brrdy", 32'(br_ready),  32'(eb));
            chk("m_jrdy",  32'(j_ready),   32'(ej));
            chk("m_valid", 32'(tgt_valid), 32'(ev));
            if (ev) begin
                chk("m_addr", tgt_addr,     m_addr);
                chk("m_src",  32'(tgt_src), 32'(m_src));
            end
            if (eb || ej) begin
                m_pend = 1'b1;
                m_acc  = m_cyc;
                m_src  = ej;
                m_last = ej;
                m_addr = ej ? {j_pc_plus4[31:28], j_index, 2'b00}
                            : br_pc_plus4 + (br_imm_ext << 2);
            end else if (ev && tgt_ready) begin
                m_pend = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready(input bit isbr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (isbr ? br_ready : j_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Issue one request, check latency and result; returns at the first
    // negedge where tgt_valid is high.
    task automatic txn(input bit isbr, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_addr, input logic exp_src, input string nm);
        bit ok;
        int k;
        @(posedge clk); #1;
        if (isbr) begin
            br_valid = 1'b1; br_pc_plus4 = a; br_imm_ext = b;
        end else begin
            j_valid = 1'b1; j_pc_plus4 = a; j_index = b[25:0];
        end
        wait_ready(isbr, ok);
        chk({nm, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        br_valid = 1'b0;
        j_valid  = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tgt_valid && k < 10);
        chk({nm, "_latency"}, 32'(k), 32'd2);
        chk({nm, "_addr"}, tgt_addr, exp_addr);
        chk({nm, "_src"}, 32'(tgt_src), 32'(exp_src));
    endtask

    logic bacc, jacc;

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test-plan arithmetic vectors.
        txn(1'b1, 32'h00400004, 32'h00000003, 32'h00400010, SRC_BRANCH, "br_basic");
        txn(1'b1, 32'h00400004, 32'hFFFFFFFF, 32'h00400000, SRC_BRANCH, "br_neg");
        txn(1'b1, 32'hFFFFFFFC, 32'h00000002, 32'h00000004, SRC_BRANCH, "br_wrap");
        txn(1'b0, 32'h00400008, 32'h00100005, 32'h00400014, SRC_JUMP,   "jump");
        txn(1'b0, 32'hA0000000, 32'h03FFFFFF, 32'hAFFFFFFC, SRC_JUMP,   "jump_max");

        // Backpressure: result held, next request waits until one cycle after the take.
        @(posedge clk); #1 tgt_ready = 1'b0;
        txn(1'b1, 32'h10000000, 32'h00000010, 32'h10000040, SRC_BRANCH, "bp_first");
        @(posedge clk); #1;
        br_valid = 1'b1; br_pc_plus4 = 32'h20000000; br_imm_ext = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(tgt_valid), 32'd1);
            chk("bp_hold_addr",  tgt_addr, 32'h10000040);
            chk("bp_hold_brrdy", 32'(br_ready), 32'd0);
        end
        @(posedge clk); #1 tgt_ready = 1'b1;
        @(negedge clk);
        chk("bp_take_brrdy", 32'(br_ready), 32'd0);
        @(negedge clk);
        chk("bp_next_accept", 32'(br_ready), 32'd1);
        @(posedge clk); #1 br_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Reset in CALC, then a tie right after release.
        #1;
        br_valid = 1'b1; br_pc_plus4 = 32'h00400004; br_imm_ext = 32'h5;
        wait_ready(1'b1, ok);
        chk("rstcalc_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        br_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstcalc_valid", 32'(tgt_valid), 32'd0);
        chk("rstcalc_addr",  tgt_addr, 32'd0);
        br_valid = 1'b1; br_pc_plus4 = 32'h00001000; br_imm_ext = 32'h4;
        j_valid  = 1'b1; j_pc_plus4  = 32'h30000000; j_index    = 26'h0000040;
        #1;
        chk("rstcalc_brrdy", 32'(br_ready), 32'd0);
        chk("rstcalc_jrdy",  32'(j_ready),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("tie1_nostale", 32'(tgt_valid), 32'd0);
        chk("tie1_br", 32'(br_ready), 32'd1);
        chk("tie1_j",  32'(j_ready),  32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (br_ready || j_ready) break;
        end
`ifdef TARGET_ARB_RR_EN
        chk("tie2_j", 32'(j_ready), 32'd1);
`else
        chk("tie2_br", 32'(br_ready), 32'd1);
`endif
        @(posedge clk); #1;
        br_valid = 1'b0;
        j_valid  = 1'b0;
        repeat (4) @(posedge clk);

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            @(negedge clk);
            bacc = br_ready;
            jacc = j_ready;
            @(posedge clk); #1;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            if (!br_valid || bacc) begin
                r = $urandom;
                br_valid    = ($urandom_range(0, 2) != 0);
                br_pc_plus4 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
                br_imm_ext  = ($urandom_range(0, 3) == 0) ? $urandom : {{16{r[15]}}, r[15:0]};
            end
            if (!j_valid || jacc) begin
                j_valid    = ($urandom_range(0, 2) != 0);
                j_pc_plus4 = $urandom;
                j_index    = 26'($urandom);
            end
            tgt_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        br_valid  = 1'b0;
        j_valid   = 1'b0;
        tgt_ready = 1'b1;
        repeat (6) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
